// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined small-float multiplier, approximate (Mitchell) or exact truncated mantissa per transaction.
// Latency 3 cycles, 1 result/cycle; the whole pipe stalls together while out_valid && !out_ready.
module fp_mul_pipe #(
    parameter int EXP_BITS      = 4,
    parameter int MANTISSA_BITS = 3,
    parameter int BIAS          = (1 << (EXP_BITS - 1)) - 1,
    parameter int CNT_W         = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [EXP_BITS+MANTISSA_BITS:0]    in_a,
    input  logic [EXP_BITS+MANTISSA_BITS:0]    in_b,
    input  logic                               in_mode,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [EXP_BITS+MANTISSA_BITS:0]    out_data,
    output logic                               out_zero,
    output logic                               out_udf,
    output logic                               out_ovf,
    input  logic                               cnt_clr,
    output logic [CNT_W-1:0]                   ovf_cnt,
    output logic [CNT_W-1:0]                   udf_cnt
);
    localparam int M  = MANTISSA_BITS;
    localparam int E  = EXP_BITS;
    localparam int W  = 1 + E + M;
    localparam int EW = E + 3;
    localparam logic [EW-1:0] BIAS_W = EW'(BIAS);
    localparam logic [EW-1:0] EMAX_W = EW'((1 << E) - 1);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: operand capture
    logic         s1_vld;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s1_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_mode <= 1'b0;
        end else if (adv) begin
            s1_vld  <= in_valid;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_mode <= in_mode;
        end
    end

    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] ma, mb;
    assign {sa, ea, ma} = s1_a;
    assign {sb, eb, mb} = s1_b;

    logic [M:0]       m_sum;
    logic [2*M+1:0]   p;
    logic             unused_p;
    logic             carry;
    logic [M-1:0]     mant;
    logic [EW-1:0]    e_raw;

    assign m_sum    = {1'b0, ma} + {1'b0, mb};
    assign p        = (2*M+2)'({1'b1, ma}) * (2*M+2)'({1'b1, mb});
    assign unused_p = ^p[M-1:0];

    always_comb begin
        carry = 1'b0;
        mant  = '0;
        if (s1_mode) begin
            if (p[2*M+1]) begin
                carry = 1'b1;
                mant  = p[2*M:M+1];
            end else begin
                carry = 1'b0;
                mant  = p[2*M-1:M];
            end
        end else begin
            carry = m_sum[M];
            mant  = m_sum[M-1:0];
        end
    end

    // Two's-complement arithmetic; bit EW-1 is the sign of the biased exponent.
    assign e_raw = {3'b000, ea} + {3'b000, eb} - BIAS_W + {{(EW-1){1'b0}}, carry};

    // Stage 2: mantissa result, carry folded into raw exponent
    logic          s2_vld;
    logic          s2_sign;
    logic          s2_zero;
    logic [M-1:0]  s2_mant;
    logic [EW-1:0] s2_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_mant <= '0;
            s2_exp  <= '0;
        end else if (adv) begin
            s2_vld  <= s1_vld;
            s2_sign <= sa ^ sb;
            s2_zero <= (ea == '0) || (eb == '0);
            s2_mant <= mant;
            s2_exp  <= e_raw;
        end
    end

    logic [W-1:0] nxt_data;
    logic         nxt_zero, nxt_udf, nxt_ovf;

    always_comb begin
        nxt_data = '0;
        nxt_zero = 1'b0;
        nxt_udf  = 1'b0;
        nxt_ovf  = 1'b0;
        if (s2_zero) begin
            nxt_data = {s2_sign, {(W-1){1'b0}}};
            nxt_zero = 1'b1;
        end else if (s2_exp[EW-1] || (s2_exp == '0)) begin
            nxt_data = {s2_sign, {(W-1){1'b0}}};
            nxt_udf  = 1'b1;
        end else if (s2_exp > EMAX_W) begin
            nxt_data = {s2_sign, {(W-1){1'b1}}};
            nxt_ovf  = 1'b1;
        end else begin
            nxt_data = {s2_sign, s2_exp[E-1:0], s2_mant};
        end
    end

    // Stage 3: classified, packed output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_udf   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_vld;
            out_data  <= nxt_data;
            out_zero  <= nxt_zero;
            out_udf   <= nxt_udf;
            out_ovf   <= nxt_ovf;
        end
    end

    logic delivered;
    assign delivered = out_valid && out_ready;

    // Saturating event counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (delivered && out_ovf && (ovf_cnt != {CNT_W{1'b1}}))
                ovf_cnt <= ovf_cnt + 1'b1;
            if (delivered && out_udf && (udf_cnt != {CNT_W{1'b1}}))
                udf_cnt <= udf_cnt + 1'b1;
        end
    end

endmodule
